// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus request mux and response scatter.
package bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_U    = 2'd3
    } owner_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'h0000_0000;

    // The order of these checks matches the request mux arbitration order.
    function automatic owner_t rd_owner_pick(input logic i_req, input logic d_req, input logic u_req);
        if (u_req)      return OWN_U;
        else if (i_req) return OWN_I;
        else if (d_req) return OWN_D;
        else            return OWN_NONE;
    endfunction

    function automatic owner_t wr_owner_pick(input logic d_req, input logic u_req);
        if (u_req)      return OWN_U;
        else if (d_req) return OWN_D;
        else            return OWN_NONE;
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Pending-op watchdog for bus_scatter; only instantiated when BUS_TIMEOUT_EN is defined.
module bus_timeout_cnt #(
    parameter int TO_W        = 10,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (run_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = run_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/bus_scatter.sv
// Response side of the shared memory bus: remembers who owns the outstanding read/write
// and routes the qspi completion back to that owner. Optional watchdog under BUS_TIMEOUT_EN.
module bus_scatter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_req,
    input  logic        d_read_req,
    input  logic        d_write_req,
    input  logic        u_read_req,
    input  logic        u_write_req,
    input  logic        read_valid,
    input  logic [31:0] read_data,
    input  logic        write_done,
    output logic        i_read_valid,
    output logic        d_read_valid,
    output logic        u_read_valid,
    output logic [31:0] rd_data,
    output logic        d_write_done,
    output logic        u_write_done,
    output logic        bus_busy,
    output logic        bus_err
);

    if ((2 ** TO_W) < TIMEOUT_CYC) begin : g_bad_to_w
        $error("TO_W too narrow for TIMEOUT_CYC");
    end

    state_t      state_q, state_d;
    owner_t      rd_own_q, rd_own_d;
    owner_t      wr_own_q, wr_own_d;
    logic        i_rv_q, i_rv_d;
    logic        d_rv_q, d_rv_d;
    logic        u_rv_q, u_rv_d;
    logic        d_wd_q, d_wd_d;
    logic        u_wd_q, u_wd_d;
    logic        err_q, err_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic rd_req, wr_req, rd_pend, wr_pend;
    logic rd_cap, wr_cap, rd_done, wr_done, rd_to, wr_to, rd_fin, wr_fin;
    logic to_exp;

    assign rd_req  = i_read_req | d_read_req | u_read_req;
    assign wr_req  = d_write_req | u_write_req;
    assign rd_pend = (rd_own_q != OWN_NONE);
    assign wr_pend = (wr_own_q != OWN_NONE);

    // A slot that is completing this cycle is still occupied, so a same-cycle strobe is dropped.
    assign rd_cap  = rd_req && !rd_pend;
    assign wr_cap  = wr_req && !wr_pend;
    assign rd_done = read_valid && rd_pend;
    assign wr_done = write_done && wr_pend;
    assign rd_to   = to_exp && rd_pend && !rd_done;
    assign wr_to   = to_exp && wr_pend && !wr_done;
    assign rd_fin  = rd_done | rd_to;
    assign wr_fin  = wr_done | wr_to;

`ifdef BUS_TIMEOUT_EN
    bus_timeout_cnt #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (rd_fin | wr_fin | rd_cap | wr_cap),
        .run_i    (state_q == ST_WAIT),
        .expire_o (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif

    always_comb begin
        rd_own_d  = rd_own_q;
        wr_own_d  = wr_own_q;
        rd_data_d = rd_data_q;
        i_rv_d    = 1'b0;
        d_rv_d    = 1'b0;
        u_rv_d    = 1'b0;
        d_wd_d    = 1'b0;
        u_wd_d    = 1'b0;
        err_d     = rd_to | wr_to;

        if (rd_fin) begin
            i_rv_d    = (rd_own_q == OWN_I);
            d_rv_d    = (rd_own_q == OWN_D);
            u_rv_d    = (rd_own_q == OWN_U);
            rd_data_d = rd_done ? read_data : TIMEOUT_DATA;
            rd_own_d  = OWN_NONE;
        end else if (rd_cap) begin
            rd_own_d  = rd_owner_pick(i_read_req, d_read_req, u_read_req);
        end

        if (wr_fin) begin
            d_wd_d   = (wr_own_q == OWN_D);
            u_wd_d   = (wr_own_q == OWN_U);
            wr_own_d = OWN_NONE;
        end else if (wr_cap) begin
            wr_own_d = wr_owner_pick(d_write_req, u_write_req);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rd_cap || wr_cap) state_d = ST_WAIT;
            ST_WAIT: if (rd_own_d == OWN_NONE && wr_own_d == OWN_NONE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_own_q  <= OWN_NONE;
            wr_own_q  <= OWN_NONE;
            rd_data_q <= '0;
            i_rv_q    <= 1'b0;
            d_rv_q    <= 1'b0;
            u_rv_q    <= 1'b0;
            d_wd_q    <= 1'b0;
            u_wd_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_own_q  <= rd_own_d;
            wr_own_q  <= wr_own_d;
            rd_data_q <= rd_data_d;
            i_rv_q    <= i_rv_d;
            d_rv_q    <= d_rv_d;
            u_rv_q    <= u_rv_d;
            d_wd_q    <= d_wd_d;
            u_wd_q    <= u_wd_d;
            err_q     <= err_d;
        end
    end

    a_rd_collide: assert property (@(posedge clk) disable iff (rst) !(rd_req && rd_pend))
        else $error("read strobe while a read is already pending");
    a_wr_collide: assert property (@(posedge clk) disable iff (rst) !(wr_req && wr_pend))
        else $error("write strobe while a write is already pending");

    assign i_read_valid = i_rv_q;
    assign d_read_valid = d_rv_q;
    assign u_read_valid = u_rv_q;
    assign rd_data      = rd_data_q;
    assign d_write_done = d_wd_q;
    assign u_write_done = u_wd_q;
    assign bus_busy     = (state_q == ST_WAIT);
    assign bus_err      = err_q;

endmodule
